// File: rtl/fpmult_pkg.sv
// fpmult_pkg: shared constants and types for the floating-point multiplier
// back end.
//   - EXPONENT / MANTISSA global defines set the field widths (default 5 / 10)
//   - flag bit indices {NV, DZ, OF, UF, NX}
//   - InputExc bit indices {any, nan, inf, zero, snan}
//   - canonical quiet NaN
//   - output buffer state encoding
`ifndef EXPONENT
`define EXPONENT 5
`endif
`ifndef MANTISSA
`define MANTISSA 10
`endif

package fpmult_pkg;
    localparam int EXP_W  = `EXPONENT;
    localparam int MAN_W  = `MANTISSA;
    localparam int DWIDTH = EXP_W + MAN_W + 1;
    localparam int FLAG_W = 5;
    localparam int EXC_W  = 5;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int EXC_ANY  = 4;
    localparam int EXC_NAN  = 3;
    localparam int EXC_INF  = 2;
    localparam int EXC_ZERO = 1;
    localparam int EXC_SNAN = 0;

    // Positive quiet NaN: exponent all ones, mantissa MSB set.
    localparam logic [DWIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;
endpackage

// File: rtl/fpmult_round_pack_if.sv
// fpmult_round_pack_if: operand bundle in, packed result out.
//   upstream  : in_valid/in_ready, RoundE, RoundEP, RoundM, RoundMP, Sp, GRS,
//               EUnf, InputExc
//   downstream: out_valid/out_ready, Z, Flags, StickyFlags, flag_clr
//   modport slave  = the rounding stage, modport master = its environment.
interface fpmult_round_pack_if;
    import fpmult_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [EXP_W-1:0]    RoundE;
    logic [EXP_W-1:0]    RoundEP;
    logic [MAN_W-1:0]    RoundM;
    logic [MAN_W-1:0]    RoundMP;
    logic                Sp;
    logic [2:0]          GRS;
    logic                EUnf;
    logic [EXC_W-1:0]    InputExc;
    logic                flag_clr;
    logic                out_valid;
    logic                out_ready;
    logic [DWIDTH-1:0]   Z;
    logic [FLAG_W-1:0]   Flags;
    logic [FLAG_W-1:0]   StickyFlags;

    modport slave (
        input  in_valid, RoundE, RoundEP, RoundM, RoundMP, Sp, GRS, EUnf, InputExc,
        input  flag_clr, out_ready,
        output in_ready, out_valid, Z, Flags, StickyFlags
    );

    modport master (
        output in_valid, RoundE, RoundEP, RoundM, RoundMP, Sp, GRS, EUnf, InputExc,
        output flag_clr, out_ready,
        input  in_ready, out_valid, Z, Flags, StickyFlags
    );
endinterface

// File: rtl/fpmult_skid_buffer.sv
// fpmult_skid_buffer: generic two-entry valid/ready buffer, strict FIFO order.
//   clk, rst (async, active low)
//   i_valid/o_ready/i_data : upstream side
//   o_valid/i_ready/o_data : downstream side, o_data always from main register
// o_ready depends only on the state register, so upstream never sees a
// combinational path from i_ready.
module fpmult_skid_buffer
    import fpmult_pkg::*;
#(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    buf_state_t r_state, w_state_next;
    logic [W-1:0] r_main, r_skid;
    logic w_accept, w_drain;
    logic w_main_from_in, w_main_from_skid, w_skid_from_in;

    always_comb begin
        w_state_next     = r_state;
        w_main_from_in   = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_from_in   = 1'b0;
        w_accept         = i_valid && (r_state != BUF_FULL);
        w_drain          = (r_state != BUF_EMPTY) && i_ready;
        case (r_state)
            BUF_EMPTY: begin
                if (w_accept) begin
                    w_state_next   = BUF_ONE;
                    w_main_from_in = 1'b1;
                end
            end
            BUF_ONE: begin
                if (w_accept && w_drain) begin
                    w_main_from_in = 1'b1;
                end else if (w_accept) begin
                    w_state_next   = BUF_FULL;
                    w_skid_from_in = 1'b1;
                end else if (w_drain) begin
                    w_state_next = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                // No accept possible here; the older skid entry moves up.
                if (w_drain) begin
                    w_state_next     = BUF_ONE;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_main_from_in) begin
                r_main <= i_data;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_from_in) begin
                r_skid <= i_data;
            end
        end
    end

    assign o_ready = (r_state != BUF_FULL);
    assign o_valid = (r_state != BUF_EMPTY);
    assign o_data  = r_main;
endmodule

// File: rtl/fpmult_round_pack.sv
// fpmult_round_pack: round-to-nearest-even, overflow / special-operand
// handling and IEEE packing, followed by a two-entry output buffer.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : fpmult_round_pack_if.slave (operand bundle in, Z/Flags out)
// Optional feature macro: FPMULT_ROUND_STICKY_FLAGS_EN builds the
// StickyFlags accumulator; otherwise StickyFlags is 0 and flag_clr is ignored.
module fpmult_round_pack
    import fpmult_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fpmult_round_pack_if.slave bus
);
    logic               w_up;
    logic [MAN_W-1:0]   w_man;
    logic [EXP_W-1:0]   w_exp;
    logic [DWIDTH-1:0]  w_z;
    logic [FLAG_W-1:0]  w_flags;
    logic [FLAG_W-1:0]  w_out_flags;
    logic [DWIDTH-1:0]  w_out_z;
    logic               w_out_valid;
    logic               w_drain;
    logic               unused_exc_any;

    // Nearest-even: round up above half, or at exactly half when LSB is odd.
    assign w_up  = bus.GRS[2] & (bus.GRS[1] | bus.GRS[0] | bus.RoundM[0]);
    assign w_man = w_up ? bus.RoundMP : bus.RoundM;
    // RoundMP wrapping to zero means the increment carried out of the mantissa.
    assign w_exp = (w_up && (bus.RoundMP == '0)) ? bus.RoundEP : bus.RoundE;

    always_comb begin
        w_z              = {bus.Sp, w_exp, w_man};
        w_flags          = '0;
        w_flags[FLAG_NX] = |bus.GRS;
        if (bus.InputExc[EXC_NAN]) begin
            w_z              = QNAN;
            w_flags          = '0;
            w_flags[FLAG_NV] = bus.InputExc[EXC_SNAN];
        end else if (bus.InputExc[EXC_INF]) begin
            w_z     = {bus.Sp, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags = '0;
        end else if (bus.InputExc[EXC_ZERO]) begin
            w_z     = {bus.Sp, {(DWIDTH-1){1'b0}}};
            w_flags = '0;
        end else if (bus.EUnf) begin
            w_z              = {bus.Sp, {(DWIDTH-1){1'b0}}};
            w_flags          = '0;
            w_flags[FLAG_UF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else if (&w_exp) begin
            w_z              = {bus.Sp, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_flags          = '0;
            w_flags[FLAG_OF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end
    end

    // The summary "any" bit carries no information beyond nan/inf/zero.
    assign unused_exc_any = bus.InputExc[EXC_ANY];

    fpmult_skid_buffer #(
        .W (DWIDTH + FLAG_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  ({w_flags, w_z}),
        .o_valid (w_out_valid),
        .i_ready (bus.out_ready),
        .o_data  ({w_out_flags, w_out_z})
    );

    assign bus.out_valid = w_out_valid;
    assign bus.Z         = w_out_z;
    assign bus.Flags     = w_out_flags;
    assign w_drain       = w_out_valid & bus.out_ready;

`ifdef FPMULT_ROUND_STICKY_FLAGS_EN
    logic [FLAG_W-1:0] r_sticky;

    // A clear coinciding with a drain keeps only the drained result's flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sticky <= '0;
        end else if (w_drain) begin
            r_sticky <= bus.flag_clr ? w_out_flags : (r_sticky | w_out_flags);
        end else if (bus.flag_clr) begin
            r_sticky <= '0;
        end
    end

    assign bus.StickyFlags = r_sticky;
`else
    logic unused_sticky_inputs;

    assign unused_sticky_inputs = bus.flag_clr ^ w_drain;
    assign bus.StickyFlags      = '0;
`endif
endmodule

// File: tb/tb_fpmult_round_pack.sv
module tb_fpmult_round_pack;
    import fpmult_pkg::*;

    typedef struct packed {
        logic [4:0] e;
        logic [4:0] ep;
        logic [9:0] m;
        logic [9:0] mp;
        logic       sp;
        logic [2:0] grs;
        logic       eunf;
        logic [4:0] exc;
    } bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpmult_round_pack_if bus();

    fpmult_round_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [4:0] sticky_model = '0;

    function automatic bundle_t mk(input logic [4:0] e, input logic [4:0] ep,
                                   input logic [9:0] m, input logic [9:0] mp,
                                   input logic sp, input logic [2:0] grs,
                                   input logic eunf, input logic [4:0] exc);
        bundle_t b;
        b.e = e; b.ep = ep; b.m = m; b.mp = mp;
        b.sp = sp; b.grs = grs; b.eunf = eunf; b.exc = exc;
        return b;
    endfunction

    // Consistent bundle as the normalize stage would produce it.
    function automatic bundle_t rand_bundle();
        bundle_t b;
        logic [3:0] r;
        b.e    = 5'($urandom_range(0, 30));
        b.ep   = b.e + 5'd1;
        b.m    = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom);
        b.mp   = b.m + 10'd1;
        b.sp   = 1'($urandom);
        b.grs  = 3'($urandom);
        b.eunf = ($urandom_range(0, 7) == 0);
        b.exc  = '0;
        if ($urandom_range(0, 3) == 0) begin
            r     = 4'($urandom);
            b.exc = {|r[3:1], r};
        end
        return b;
    endfunction

    // Reference: {Flags, Z}. Rounding done by integer addition on the packed
    // magnitude, so a mantissa carry naturally bumps the exponent.
    function automatic logic [20:0] ref_model(input bundle_t b);
        logic [4:0]  f;
        logic [15:0] z;
        int          rem;
        int          mag;
        logic        up;
        logic [14:0] mb;
        f = '0;
        if (b.exc[3]) begin
            z = 16'h7E00;
            f[4] = b.exc[0];
        end else if (b.exc[2]) begin
            z = {b.sp, 15'h7C00};
        end else if (b.exc[1]) begin
            z = {b.sp, 15'h0000};
        end else if (b.eunf) begin
            z = {b.sp, 15'h0000};
            f = 5'b00011;
        end else begin
            rem = (b.grs[2] ? 2 : 0) + ((b.grs[1] || b.grs[0]) ? 1 : 0);
            up  = (rem > 2) || (rem == 2 && b.m[0]);
            mag = int'(b.e) * 1024 + int'(b.m) + (up ? 1 : 0);
            if (mag >= 31 * 1024) begin
                z = {b.sp, 15'h7C00};
                f = 5'b00101;
            end else begin
                mb = mag[14:0];
                z  = {b.sp, mb};
                f[0] = (b.grs != 3'b000);
            end
        end
        return {f, z};
    endfunction

    task automatic apply(input bundle_t b);
        bus.RoundE   = b.e;
        bus.RoundEP  = b.ep;
        bus.RoundM   = b.m;
        bus.RoundMP  = b.mp;
        bus.Sp       = b.sp;
        bus.GRS      = b.grs;
        bus.EUnf     = b.eunf;
        bus.InputExc = b.exc;
    endtask

    // Drives one bundle into an empty stage; returns at the negedge after the accept edge.
    task automatic send(input bundle_t b);
        @(negedge clk);
        apply(b);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.out_ready = 0; bus.flag_clr = 0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        #1 rst = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.Z !== 16'h0 || bus.Flags !== 5'h0 || bus.StickyFlags !== 5'h0) begin
            errors++;
            $display("FAIL reset_data: Z=%h Flags=%h Sticky=%h required 0", bus.Z, bus.Flags, bus.StickyFlags);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        $display("reset: out_valid=%b in_ready=%b Z=%h", bus.out_valid, bus.in_ready, bus.Z);
    endtask

    task automatic test_rounding();
        bundle_t     vec [0:3];
        logic [15:0] z_exp [0:3];
        logic [4:0]  f_exp [0:3];
        vec[0] = mk(5'h0F, 5'h10, 10'h155, 10'h156, 1'b0, 3'b000, 1'b0, 5'h0);
        z_exp[0] = 16'h3D55; f_exp[0] = 5'h00;   // exact
        vec[1] = mk(5'h0F, 5'h10, 10'h3FF, 10'h000, 1'b0, 3'b100, 1'b0, 5'h0);
        z_exp[1] = 16'h4000; f_exp[1] = 5'h01;   // tie, odd LSB, carry-out
        vec[2] = mk(5'h1E, 5'h1F, 10'h3FF, 10'h000, 1'b1, 3'b110, 1'b0, 5'h0);
        z_exp[2] = 16'hFC00; f_exp[2] = 5'h05;   // overflow
        vec[3] = mk(5'h0F, 5'h10, 10'h154, 10'h155, 1'b0, 3'b100, 1'b0, 5'h0);
        z_exp[3] = 16'h3D54; f_exp[3] = 5'h01;   // tie, even LSB stays
        for (int i = 0; i < 4; i++) begin
            send(vec[i]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.Z !== z_exp[i] || bus.Flags !== f_exp[i]) begin
                errors++;
                $display("FAIL rounding_%0d: valid=%b Z=%h Flags=%h required 1 Z=%h Flags=%h",
                         i, bus.out_valid, bus.Z, bus.Flags, z_exp[i], f_exp[i]);
            end
            $display("rounding %0d: Z=%h Flags=%h", i, bus.Z, bus.Flags);
        end
    endtask

    task automatic test_special();
        bundle_t     vec [0:4];
        logic [15:0] z_exp [0:4];
        logic [4:0]  f_exp [0:4];
        vec[0] = mk(5'h0F, 5'h10, 10'h123, 10'h124, 1'b1, 3'b111, 1'b0, 5'b11001);
        z_exp[0] = 16'h7E00; f_exp[0] = 5'h10;   // sNaN
        vec[1] = mk(5'h0F, 5'h10, 10'h123, 10'h124, 1'b1, 3'b111, 1'b1, 5'b10010);
        z_exp[1] = 16'h8000; f_exp[1] = 5'h00;   // zero beats EUnf
        vec[2] = mk(5'h0F, 5'h10, 10'h123, 10'h124, 1'b0, 3'b101, 1'b0, 5'b10110);
        z_exp[2] = 16'h7C00; f_exp[2] = 5'h00;   // inf beats zero
        vec[3] = mk(5'h01, 5'h02, 10'h0FF, 10'h100, 1'b1, 3'b001, 1'b1, 5'b00000);
        z_exp[3] = 16'h8000; f_exp[3] = 5'h03;   // underflow flush
        vec[4] = mk(5'h0F, 5'h10, 10'h123, 10'h124, 1'b0, 3'b000, 1'b0, 5'b11100);
        z_exp[4] = 16'h7E00; f_exp[4] = 5'h00;   // qNaN beats inf
        for (int i = 0; i < 5; i++) begin
            send(vec[i]);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.Z !== z_exp[i] || bus.Flags !== f_exp[i]) begin
                errors++;
                $display("FAIL special_%0d: valid=%b Z=%h Flags=%h required 1 Z=%h Flags=%h",
                         i, bus.out_valid, bus.Z, bus.Flags, z_exp[i], f_exp[i]);
            end
            $display("special %0d: Z=%h Flags=%h", i, bus.Z, bus.Flags);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] z_exp [0:2];
        int got;
        logic c_taken;
        z_exp[0] = 16'h3C01; z_exp[1] = 16'h3C02; z_exp[2] = 16'h3C03;
        @(negedge clk);
        bus.out_ready = 1'b0;
        apply(mk(5'h0F, 5'h10, 10'h001, 10'h002, 1'b0, 3'b000, 1'b0, 5'h0));
        bus.in_valid = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_a: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); @(negedge clk);
        apply(mk(5'h0F, 5'h10, 10'h002, 10'h003, 1'b0, 3'b000, 1'b0, 5'h0));
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_a: out_valid=%b in_ready=%b required 1/1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); @(negedge clk);
        apply(mk(5'h0F, 5'h10, 10'h003, 10'h004, 1'b0, 3'b000, 1'b0, 5'h0));
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b required 0", bus.in_ready);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.Z !== 16'h3C01) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b Z=%h required 0 Z=3c01", bus.in_ready, bus.Z);
        end
        bus.out_ready = 1'b1;
        got = 0;
        c_taken = 1'b0;
        for (int k = 0; k < 12 && got < 3; k++) begin
            if (bus.in_valid && bus.in_ready) c_taken = 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.Z !== z_exp[got]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: Z=%h required %h", got, bus.Z, z_exp[got]);
                end
                $display("backpressure drain %0d: Z=%h", got, bus.Z);
                got++;
            end
            @(posedge clk); @(negedge clk);
            if (c_taken) bus.in_valid = 1'b0;
        end
        checks++;
        if (got != 3 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: drained=%0d out_valid=%b required 3 and 0", got, bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        send(mk(5'h1E, 5'h1F, 10'h3FF, 10'h000, 1'b0, 3'b110, 1'b0, 5'h0));
        @(posedge clk); @(negedge clk);   // overflow result drained
        bus.out_ready = 1'b0;
        apply(mk(5'h0F, 5'h10, 10'h011, 10'h012, 1'b0, 3'b000, 1'b0, 5'h0));
        bus.in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        apply(mk(5'h0F, 5'h10, 10'h022, 10'h023, 1'b0, 3'b000, 1'b0, 5'h0));
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_full: in_ready=%b out_valid=%b required 0/1", bus.in_ready, bus.out_valid);
        end
`ifdef FPMULT_ROUND_STICKY_FLAGS_EN
        checks++;
        if (bus.StickyFlags !== 5'h05) begin
            errors++;
            $display("FAIL stall_sticky: Sticky=%h required 05", bus.StickyFlags);
        end
`endif
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.StickyFlags !== 5'h0 ||
            bus.Z !== 16'h0 || bus.Flags !== 5'h0) begin
            errors++;
            $display("FAIL stall_reset: out_valid=%b in_ready=%b Sticky=%h Z=%h Flags=%h required 0/1/0/0/0",
                     bus.out_valid, bus.in_ready, bus.StickyFlags, bus.Z, bus.Flags);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        sticky_model = '0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_discard: out_valid=%b required 0", bus.out_valid);
        end
        $display("reset mid-stall: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
    endtask

    task automatic test_random(input int ncycles);
        logic [20:0] q[$];
        logic [20:0] exp_v;
        bundle_t b;
        logic acc, drn, feeding;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flag_clr = 1'b1;
        sticky_model = '0;
        @(posedge clk);
        for (int c = 0; c < ncycles + 40; c++) begin
            @(negedge clk);
            checks++;
            if (bus.StickyFlags !== sticky_model) begin
                errors++;
                $display("FAIL random_sticky cycle %0d: Sticky=%h required %h", c, bus.StickyFlags, sticky_model);
            end
            feeding = (c < ncycles);
            b = rand_bundle();
            apply(b);
            bus.in_valid  = feeding && ($urandom_range(0, 3) != 0);
            bus.out_ready = !feeding || ($urandom_range(0, 2) != 0);
            bus.flag_clr  = ($urandom_range(0, 15) == 0);
            acc = bus.in_valid && bus.in_ready;
            drn = bus.out_valid && bus.out_ready;
            if (drn) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra cycle %0d: unexpected Z=%h", c, bus.Z);
                end else begin
                    exp_v = q.pop_front();
                    if ({bus.Flags, bus.Z} !== exp_v) begin
                        errors++;
                        $display("FAIL random_result cycle %0d: Flags=%h Z=%h required Flags=%h Z=%h",
                                 c, bus.Flags, bus.Z, exp_v[20:16], exp_v[15:0]);
                    end
                    $display("random cycle %0d: Z=%h Flags=%h", c, bus.Z, bus.Flags);
`ifdef FPMULT_ROUND_STICKY_FLAGS_EN
                    sticky_model = bus.flag_clr ? exp_v[20:16] : (sticky_model | exp_v[20:16]);
`endif
                end
            end else if (bus.flag_clr) begin
                sticky_model = '0;
            end
            if (acc) q.push_back(ref_model(b));
        end
        @(negedge clk);
        bus.flag_clr = 1'b0;
        checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: pending=%0d out_valid=%b required 0/0", q.size(), bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_special();
        test_backpressure();
        test_reset_mid_stall();
        test_random(400);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
